// File: rtl/seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg_scan_ctrl
//
// Time-multiplexes a single BCD-to-7-segment decoder (7447 style) across
// DIGITS common-anode digits. Each digit owns a slot of REFRESH_DIV clocks.
// The first BLANK_CYCLES clocks of a slot keep every anode off while the
// shared decoder input already shows the new digit, so segments never ghost
// from one digit onto the next. New display values are captured into a
// shadow register on `load` and committed to the displayed register only at
// the frame boundary, so a frame never mixes old and new digits.
//
// Ports
//   clk         in   system clock, rising edge
//   rst         in   asynchronous active-high reset
//   value       in   4*DIGITS BCD nibbles, nibble i drives digit i (0 = LSD)
//   load        in   one-cycle strobe, captures value into the shadow
//   dp_mask     in   decimal-point enable per digit (registered every cycle)
//   lz_en       in   leading-zero suppression enable (registered every cycle)
//   bcd         out  nibble to the decoder bcd input
//   an_n        out  active-low anode enables
//   dp_n        out  active-low decimal point
//   frame_tick  out  one-cycle pulse in the last cycle of each frame
//   pending     out  shadow holds a value not yet committed to the display
//
// Handshake: there is no back-pressure. `load` is a plain strobe sampled on
// every rising edge; the newest strobe in a frame wins, and a strobe in the
// frame_tick cycle is committed at that same edge.
//
// Every output is decoded from registers only: dp_mask and lz_en are sampled
// into flops each cycle so no input reaches an output combinationally.
// ---------------------------------------------------------------------------
module seg_scan_ctrl #(
    parameter int DIGITS       = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  load,
    input  logic [DIGITS-1:0]     dp_mask,
    input  logic                  lz_en,
    output logic [3:0]            bcd,
    output logic [DIGITS-1:0]     an_n,
    output logic                  dp_n,
    output logic                  frame_tick,
    output logic                  pending
);

    localparam int CNTW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CNTW-1:0] CNT_LAST  = CNTW'(REFRESH_DIV - 1);
    localparam logic [CNTW-1:0] CNT_BLANK = CNTW'(BLANK_CYCLES);
    localparam logic [IDXW-1:0] IDX_LAST  = IDXW'(DIGITS - 1);

    // Slot phase is a pure decode of the slot counter.
    typedef enum logic {
        S_BLANK = 1'b0,
        S_DRIVE = 1'b1
    } slot_state_e;

    logic [CNTW-1:0]     cnt_q,     cnt_d;
    logic [IDXW-1:0]     idx_q,     idx_d;
    logic [4*DIGITS-1:0] shadow_q,  shadow_d;
    logic [4*DIGITS-1:0] disp_q,    disp_d;
    logic                pending_q, pending_d;
    logic [DIGITS-1:0]   dp_q;
    logic                lz_q;

    slot_state_e         state;
    logic                frame_end;

    assign state     = (cnt_q < CNT_BLANK) ? S_BLANK : S_DRIVE;
    assign frame_end = (idx_q == IDX_LAST) && (cnt_q == CNT_LAST);

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            shadow_q  <= '0;
            disp_q    <= '0;
            pending_q <= 1'b0;
            dp_q      <= '0;
            lz_q      <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            disp_q    <= disp_d;
            pending_q <= pending_d;
            dp_q      <= dp_mask;
            lz_q      <= lz_en;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shadow_d  = shadow_q;
        disp_d    = disp_q;
        pending_d = pending_q;

        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDXW'(1);
        end else begin
            cnt_d = cnt_q + CNTW'(1);
        end

        if (load) begin
            shadow_d  = value;
            pending_d = 1'b1;
        end

        // A load landing on the frame boundary bypasses the shadow so it is
        // not held back a whole frame; the commit always clears pending.
        if (frame_end) begin
            disp_d    = load ? value : shadow_q;
            pending_d = 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Output logic
    // -----------------------------------------------------------------------
    logic [3:0] cur_nib;
    logic       cur_dp;
    logic       nz_at_or_above;
    logic       suppress;

    always_comb begin
        cur_nib        = 4'd0;
        cur_dp         = 1'b0;
        nz_at_or_above = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDXW'(i)) begin
                cur_nib = disp_q[4*i +: 4];
                cur_dp  = dp_q[i];
            end
            if ((IDXW'(i) >= idx_q) && (disp_q[4*i +: 4] != 4'd0)) begin
                nz_at_or_above = 1'b1;
            end
        end

        // Digit 0 always lights so a zero value still shows "0".
        suppress = lz_q && (idx_q != '0) && !nz_at_or_above;

        // The decoder input tracks the slot's digit through BLANK as well,
        // giving the decoder time to settle before the anode turns on.
        bcd        = cur_nib;
        an_n       = '1;
        dp_n       = 1'b1;
        frame_tick = frame_end;
        pending    = pending_q;

        if (state == S_DRIVE && !suppress) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (idx_q == IDXW'(i)) begin
                    an_n[i] = 1'b0;
                end
            end
            dp_n = ~cur_dp;
        end
    end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexes one decoder_7447 BCD-to-7-segment decoder across DIGITS common-anode digits.
- Sequences the shared decoder input and the per-digit anode enables.
- Blanks between digits so segments do not ghost onto the next digit.
- Latches new display values only at frame boundaries, so a frame never shows half-old, half-new digits.
- Sits between the datapath (counters/registers producing BCD nibbles) and the board-level decoder and anode drivers.

Parameters:
- DIGITS, 4, number of multiplexed digits; legal range 2..8.
- REFRESH_DIV, 50000, clk cycles per digit slot; must be at least 2.
- BLANK_CYCLES, 500, cycles at the start of each slot with all anodes off; must be at least 1 and less than REFRESH_DIV.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- value  in  4*DIGITS  BCD nibbles; nibble i (bits 4i+3:4i) drives digit i; digit 0 is least significant.
- load  in  1  one-cycle strobe; captures value into the shadow register.
- dp_mask  in  DIGITS  decimal-point enable per digit, sampled live.
- lz_en  in  1  leading-zero suppression enable, sampled live.
- bcd  out  4  nibble to the decoder_7447 bcd input.
- an_n  out  DIGITS  active-low anode enables.
- dp_n  out  1  active-low decimal point.
- frame_tick  out  1  one-cycle pulse in the last cycle of each frame.
- pending  out  1  shadow holds a value not yet committed to the display.

Behaviour:
- Registers:
  - cnt: 0..REFRESH_DIV-1, position within the current slot.
  - idx: 0..DIGITS-1, digit currently being scanned.
  - shadow: 4*DIGITS bits, last captured value.
  - disp: 4*DIGITS bits, value currently displayed.
  - pending flag.
- Reset (asynchronous, any time, including mid-slot) forces:
  - cnt=0, idx=0, shadow=0, disp=0, pending=0.
  - an_n = all ones, dp_n=1, bcd=0, frame_tick=0.
- Slot 0 starts in the first cycle after rst deasserts.
- Slot FSM, two states derived from cnt:
  - BLANK while cnt < BLANK_CYCLES.
  - DRIVE while cnt >= BLANK_CYCLES.
  - cnt increments every cycle and wraps REFRESH_DIV-1 -> 0.
  - On that wrap, idx increments; idx wraps DIGITS-1 -> 0.
- Outputs are combinational from registers only; no path from any input to any output.
  - bcd = disp nibble[idx] for the whole slot, BLANK included, so the decoder settles before the anode turns on.
  - BLANK: an_n = all ones, dp_n = 1.
  - DRIVE: an_n[idx]=0 with all other anodes 1, unless digit idx is suppressed. dp_n = ~dp_mask[idx].
- Leading-zero suppression:
  - Digit i>0 is suppressed when lz_en=1 and disp nibbles i..DIGITS-1 are all zero.
  - Digit 0 is never suppressed.
  - A suppressed digit keeps an_n all ones and dp_n=1 for its entire slot.
  - Slot timing is unchanged by suppression.
- Nibbles 10..15 pass through unchanged; the decoder's letter or blank glyphs apply.
- Load and commit:
  - load=1 at an edge: shadow <= value, pending <= 1.
  - frame_tick=1 when idx=DIGITS-1 and cnt=REFRESH_DIV-1.
  - On the edge ending the frame_tick cycle: disp <= (load ? value : shadow), pending <= 0.
  - Load coincident with frame_tick: that value is committed directly, and shadow is also updated; it is not delayed a frame.
  - Multiple loads within one frame: the last one wins.
- Frame latency: DIGITS*REFRESH_DIV cycles. Commit-to-visible latency ranges from 1 cycle up to one full frame.
- Reset mid-frame discards the shadow and the pending value.

Test Plan:
- Parameters DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.
  1. Reset release, no load -> cycles 0-1 an_n=1111; cycles 2-7 an_n=1110, bcd=0. Slot 1 an_n=1101 at cycles 10-15. frame_tick high only at cycle 31, repeating every 32 cycles.
  2. load at cycle 5 with value=0x1234 -> pending=1 at cycles 6-31, bcd stays 0 through cycle 31. Frame 2: slot 0 bcd=4, slot 1 bcd=3, slot 2 bcd=2, slot 3 bcd=1. pending=0 from cycle 32.
  3. load value=0x0000 then 0x0987 within the same frame -> only 0987 is ever displayed; 0000 never appears.
  4. load value=0x5555 in cycle 31, coincident with frame_tick -> bcd=5 from cycle 32; pending stays 0.
  5. lz_en=1, disp=0x0070 -> slots 2 and 3 keep an_n=1111 throughout; slot 1 drives bcd=7; slot 0 drives bcd=0 with an_n=1110. With lz_en=0, all four anodes are driven.
  6. dp_mask=0010 -> dp_n=0 only in slot 1 DRIVE cycles (10-15). Assert rst at cycle 12 -> an_n=1111, dp_n=1, disp=0 immediately; slot 0 restarts after release.
